// File: rtl/modmul_arbiter.sv
// Round-robin arbiter/sequencer sharing one pipelined ModMul between two requesters.
// Define MODMUL_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins ties).
module modmul_arbiter #(
  parameter int K       = 54,
  parameter int MUL_LAT = 15,
  parameter int NUM_Q   = 9,
  parameter int KIDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [K-1:0]      req0_a,
  input  logic [K-1:0]      req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [K-1:0]      req1_a,
  input  logic [K-1:0]      req1_b,
  output logic              res0_valid,
  output logic [K-1:0]      res0_data,
  output logic              res1_valid,
  output logic [K-1:0]      res1_data,
  input  logic              cfg_valid,
  input  logic [KIDX_W-1:0] cfg_k,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic [K-1:0]      mm_ina,
  output logic [K-1:0]      mm_inb,
  output logic [KIDX_W-1:0] mm_current_k,
  input  logic [K-1:0]      mm_out,
  output logic              busy
);

  localparam int CW = $clog2(MUL_LAT + 2);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MUL_LAT:0]  tv_q, tid_q;
  logic [K-1:0]      ina_d, inb_d;
  logic              cfg_done_q;
  logic              gnt0, gnt1;
  logic              acc0, acc1, acc;
  logic              retire, k_ok;

`ifdef MODMUL_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
  end
`else
  logic last_q;

  // last_q == 1 means port 1 won most recently, so port 0 wins a tie
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid;
    if (req0_valid && req1_valid) begin
      gnt0 = last_q;
      gnt1 = ~last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_q <= 1'b1;
    else if (acc) last_q <= acc1;
  end
`endif

  assign req0_ready = rst_n & ~cfg_valid & gnt0;
  assign req1_ready = rst_n & ~cfg_valid & gnt1;
  assign acc0   = req0_valid & req0_ready;
  assign acc1   = req1_valid & req1_ready;
  assign acc    = acc0 | acc1;
  assign retire = tv_q[MUL_LAT];

  assign res0_valid = retire & ~tid_q[MUL_LAT];
  assign res1_valid = retire & tid_q[MUL_LAT];
  assign res0_data  = mm_out;
  assign res1_data  = mm_out;
  assign busy       = cnt_q != '0;

  assign k_ok      = cfg_k < KIDX_W'(NUM_Q);
  assign cfg_ready = rst_n & cfg_valid & (cnt_q == '0) & ~cfg_done_q;
  assign cfg_err   = cfg_ready & ~k_ok;

  always_comb begin
    ina_d = '0;
    inb_d = '0;
    unique case (1'b1)
      acc0: begin
        ina_d = req0_a;
        inb_d = req0_b;
      end
      acc1: begin
        ina_d = req1_a;
        inb_d = req1_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (acc && !retire)      cnt_d = cnt_q + CW'(1);
    else if (!acc && retire) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_q         <= '0;
      tid_q        <= '0;
      cnt_q        <= '0;
      mm_ina       <= '0;
      mm_inb       <= '0;
      mm_current_k <= '0;
      cfg_done_q   <= 1'b0;
    end else begin
      tv_q       <= {tv_q[MUL_LAT-1:0], acc};
      tid_q      <= {tid_q[MUL_LAT-1:0], acc1};
      cnt_q      <= cnt_d;
      mm_ina     <= ina_d;
      mm_inb     <= inb_d;
      // one cfg_ready pulse per cfg_valid assertion
      cfg_done_q <= cfg_valid & (cfg_done_q | cfg_ready);
      if (cfg_ready && k_ok) mm_current_k <= cfg_k;
    end
  end

endmodule

// File: doc/modmul_arbiter.md
# modmul_arbiter

Round-robin arbiter and sequencer that shares one pipelined Montgomery `ModMul` instance, together with its `IntMultiplier_54x54`, between two requesters, such as the NTT butterfly unit and the pointwise multiplier. It accepts one operation per cycle. It tracks in-flight operations with a tag pipeline so each result returns to the requester that issued it. It owns the `current_k` (RNS limb select) register and lets software change it only after all in-flight operations have drained.

## Interface
Parameters:
- `K`, 54, operand/result width
- `MUL_LAT`, 15, latency of `ModMul` from `ina`/`inb` to `out`
- `NUM_Q`, 9, number of valid moduli; `current_k` range is 0..NUM_Q-1
- `KIDX_W`, 4, width of `current_k`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req0_valid` in 1 / `req0_ready` out 1 / `req0_a`, `req0_b` in K: requester 0 operands (a, b < q)
- `req1_valid` in 1 / `req1_ready` out 1 / `req1_a`, `req1_b` in K: requester 1 operands
- `res0_valid` out 1 / `res0_data` out K: requester 0 result; no backpressure
- `res1_valid` out 1 / `res1_data` out K: requester 1 result; no backpressure
- `cfg_valid` in 1 / `cfg_k` in KIDX_W / `cfg_ready` out 1: limb-select update request
- `cfg_err` out 1: one-cycle pulse when `cfg_k` >= NUM_Q
- `mm_ina`, `mm_inb` out K: registered operands to `ModMul`
- `mm_current_k` out KIDX_W: registered limb select to `ModMul`
- `mm_out` in K: `ModMul` result
- `busy` out 1: high while any operation is in flight

## Operation
- **Arbitration**
  - `reqX_ready` = grant to X AND NOT `cfg_valid`. While `cfg_valid` is high, both requesters are blocked so the pipeline drains.
  - Only one requester valid: that requester is granted.
  - Both valid: the port not granted most recently wins.
  - The last-grant pointer updates on every accepted request.
- **Issue**
  - On acceptance, register the operands into `mm_ina`/`mm_inb`.
  - Push {valid=1, id} into a tag shift register of depth MUL_LAT+1.
  - With no acceptance, push valid=0 and hold `mm_ina`/`mm_inb` at 0.
- **Return**
  - `resX_valid` = tag-tail valid AND tag-tail id==X.
  - `res0_data` = `res1_data` = `mm_out`, passed through combinationally.
- **In-flight counter** (0..MUL_LAT+1)
  - +1 on accept, -1 on retire; both in the same cycle leaves it unchanged.
  - `busy` = counter != 0.
- **Config**
  - `cfg_ready` pulses for one cycle in the first cycle where `cfg_valid` is high and the counter is 0.
  - Valid `cfg_k`: `mm_current_k` is updated at that edge.
  - `cfg_k` >= NUM_Q: `mm_current_k` is unchanged and `cfg_err` pulses with `cfg_ready`.
- **Result format:** results are a·b·R⁻¹ mod q_k, with R = 2^72. The arbiter never alters data.

## Timing
- Request accepted at edge n → result valid in cycle n+MUL_LAT+1 (16 with defaults).
- Throughput: one operation per cycle total, across both ports.
- Results return in strict issue order, with no reordering between ports.
- Reset values: `req0_ready`/`req1_ready` = 0 while reset is asserted; all tags invalid; `res0_valid`/`res1_valid` = 0; `mm_ina`/`mm_inb` = 0; `mm_current_k` = 0; last-grant pointer = port 1, so port 0 wins the first tie; counter = 0; `cfg_ready`/`cfg_err` = 0; `busy` = 0.
- Reset mid-operation: all tags are cleared immediately and in-flight results are discarded. `mm_out` is ignored until new tags arrive.
- `cfg_valid` raised in the same cycle as a request: the request is not accepted; config takes priority.
- Counter at MUL_LAT+1 with accept and retire in the same cycle: the counter holds and there is no overflow. Accepting is always legal because the pipeline never stalls.

## Configuration
- Macro: `MODMUL_ARB_FIXED_PRIO_EN`.
- Defined: port 0 always wins ties, and the last-grant pointer is not implemented. Port 1 can starve.
- Undefined (default): round-robin as described under Operation.

## Test plan
- **Single issue:** k=0, req0 a=0, b=5 at edge n → `res0_valid`=1 and `res0_data`=0 in cycle n+16. `res1_valid` stays 0 throughout.
- **Tie:** both ports hold valid for 40 cycles with random operands < q_k → grants alternate 0,1,0,1…. Each `resX_data` equals the model a·b·R⁻¹ mod q_k, in issue order. The counter saturates at 16 and stays there.
- **Config drain:** 5 ops in flight, then `cfg_valid`=1 with `cfg_k`=3 → both readies drop. `cfg_ready` pulses exactly when the last result retires. `mm_current_k`=3 afterwards, and later results are checked against q_3.
- **Bad config:** idle, `cfg_k`=9 → `cfg_ready` and `cfg_err` pulse together and `mm_current_k` is unchanged.
- **Reset mid-flight:** assert `rst_n`=0 with 8 ops in flight → `res0_valid`/`res1_valid` stay 0 for the next 20 cycles and `busy`=0.
- **Fixed priority** (macro defined): both ports valid continuously → only port 0 is granted and `req1_ready` stays 0.
